// File: rtl/mux_table_loader_pkg.sv
// Shared geometry and state encoding for the mux table loader and its sweep counter.
// The slot count is tied to the select width so every select value addresses a real slot.
package mux_table_pkg;

    localparam int SLOT_W    = 4;
    localparam int SEL_W     = 8;
    localparam int NUM_SLOTS = 1 << SEL_W;
    localparam int TABLE_W   = SLOT_W * NUM_SLOTS;

    // fill_count is one bit wider than a slot index so it can hold NUM_SLOTS itself
    localparam logic [SEL_W:0] FILL_MAX  = (SEL_W + 1)'(NUM_SLOTS);
    localparam logic [SEL_W:0] LAST_FILL = (SEL_W + 1)'(NUM_SLOTS - 1);

    typedef enum logic {
        FILL = 1'b0,
        SCAN = 1'b1
    } loader_state_t;

endpackage

// File: rtl/mux_table_loader_if.sv
// Feeder-side stream plus the two mux inputs (din, sel) and loader status.
// master drives the nibble stream and clear; slave is the loader.
interface mux_table_loader_if;

    logic                                  in_valid;
    logic [mux_table_pkg::SLOT_W-1:0]      in_data;
    logic                                  in_ready;
    logic                                  clear;
    logic [mux_table_pkg::TABLE_W-1:0]     din;
    logic [mux_table_pkg::SEL_W-1:0]       sel;
    logic                                  sel_valid;
    logic                                  table_full;
    logic [mux_table_pkg::SEL_W:0]         fill_count;

    modport master (
        output in_valid, in_data, clear,
        input  in_ready, din, sel, sel_valid, table_full, fill_count
    );

    modport slave (
        input  in_valid, in_data, clear,
        output in_ready, din, sel, sel_valid, table_full, fill_count
    );

endinterface

// File: rtl/mux_table_loader_sel_sweep_counter.sv
// sel_sweep_counter: wrapping slot-index sweep for the downstream mux select.
// Latency: first enabled edge raises sel_valid with sel = 0; each later enabled edge steps sel by one.
// Backpressure: none; enable gates the sweep, clr or reset returns it to idle.
module sel_sweep_counter
    import mux_table_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             clr,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid
);

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            sel       <= '0;
            sel_valid <= 1'b0;
        end else if (en) begin
            // the enabling edge only arms the sweep so slot 0 gets a full cycle
            if (sel_valid) begin
                sel <= sel + SEL_W'(1);
            end
            sel_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/mux_table_loader.sv
// mux_table_loader: packs the nibble stream into the 256-slot din table, then sweeps sel over it (MUX_TABLE_LOADER_OVERWRITE_EN keeps writes open while sweeping).
// Latency: a write lands on din, fill_count and table_full one cycle after its accept; sel = 0 appears the cycle after the last fill.
// Backpressure: in_ready is low in SCAN (unless overwrite is built in), while resetn is low and while clear is high.
module mux_table_loader
    import mux_table_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    mux_table_loader_if.slave bus
);

    loader_state_t      state;
    logic [SEL_W-1:0]   wr_ptr;
    logic [SEL_W:0]     fill_count;
    logic [TABLE_W-1:0] din;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;

    logic scan_open;
    logic in_ready;
    logic accept;
    logic fill_done;
    logic sweep_en;

`ifdef MUX_TABLE_LOADER_OVERWRITE_EN
    assign scan_open = 1'b1;
`else
    assign scan_open = 1'b0;
`endif

    // ready is a function of state and the restart inputs only, never of in_valid
    assign in_ready  = resetn & ~bus.clear & ((state == FILL) | scan_open);
    assign accept    = bus.in_valid & in_ready;
    assign fill_done = accept & (state == FILL) & (fill_count == LAST_FILL);
    assign sweep_en  = fill_done | (state == SCAN);

    always_ff @(posedge clk) begin
        if (!resetn || bus.clear) begin
            state      <= FILL;
            wr_ptr     <= '0;
            fill_count <= '0;
            din        <= '0;
        end else if (accept) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (wr_ptr == SEL_W'(k)) begin
                    din[k*SLOT_W +: SLOT_W] <= bus.in_data;
                end
            end
            wr_ptr <= wr_ptr + SEL_W'(1);
            // saturates so overwrites during SCAN keep reporting a full table
            if (fill_count != FILL_MAX) begin
                fill_count <= fill_count + (SEL_W + 1)'(1);
            end
            if (fill_done) begin
                state <= SCAN;
            end
        end
    end

    sel_sweep_counter u_sweep (
        .clk       (clk),
        .resetn    (resetn),
        .en        (sweep_en),
        .clr       (bus.clear),
        .sel       (sel),
        .sel_valid (sel_valid)
    );

    assign bus.in_ready   = in_ready;
    assign bus.din        = din;
    assign bus.sel        = sel;
    assign bus.sel_valid  = sel_valid;
    assign bus.table_full = (state == SCAN);
    assign bus.fill_count = fill_count;

endmodule

// File: tb/tb_mux_table_loader.sv
// Bench for mux_table_loader: table-driven handshake vectors, fill/sweep/clear/reset sequences,
// and a scoreboard of slot writes and swept mux outputs against a behavioural model.
`timescale 1ns/1ps
module tb_mux_table_loader;
    import mux_table_pkg::*;

`ifdef MUX_TABLE_LOADER_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mux_table_loader_if bus();

    mux_table_loader dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // downstream 256-to-1 nibble mux
    logic [SLOT_W-1:0] dout;
    assign dout = bus.din[int'(bus.sel)*SLOT_W +: SLOT_W];

    typedef struct {
        int                idx;
        logic [SLOT_W-1:0] val;
    } exp_t;

    typedef struct {
        bit                v;
        logic [SLOT_W-1:0] d;
        bit                c;
        bit                r;
        int                exp_fill;
        bit                exp_full;
    } vec_t;

    exp_t wr_q[$];
    exp_t sw_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int                m_fill, m_wr, m_sel;
    bit                m_scan, m_selv;
    logic [SLOT_W-1:0] mdl [NUM_SLOTS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_din(input string name);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (bus.din[k*SLOT_W +: SLOT_W] !== mdl[k]) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: %0d slots differ, first slot %0d got %0h expected %0h",
                     name, bad, first, bus.din[first*SLOT_W +: SLOT_W], mdl[first]);
        end
    endtask

    task automatic model_reset();
        m_fill = 0; m_wr = 0; m_sel = 0; m_scan = 0; m_selv = 0;
        for (int k = 0; k < NUM_SLOTS; k++) mdl[k] = '0;
        wr_q.delete();
        sw_q.delete();
    endtask

    // expectations for the coming edge are pushed here, at drive time
    task automatic model_edge(input bit acc, input logic [SLOT_W-1:0] d, input bit zap);
        exp_t e;
        bit   was_scan;
        was_scan = m_scan;
        if (zap) begin
            model_reset();
        end else begin
            if (was_scan) m_sel = (m_sel + 1) % NUM_SLOTS;
            if (acc) begin
                mdl[m_wr] = d;
                e.idx = m_wr; e.val = d;
                wr_q.push_back(e);
                m_wr = (m_wr + 1) % NUM_SLOTS;
                if (m_fill < NUM_SLOTS) m_fill++;
                if (!was_scan && m_fill == NUM_SLOTS) begin
                    m_scan = 1; m_sel = 0; m_selv = 1;
                end
            end
            if (m_selv) begin
                e.idx = m_sel; e.val = mdl[m_sel];
                sw_q.push_back(e);
            end
        end
    endtask

    task automatic cycle(input bit v, input logic [SLOT_W-1:0] d, input bit c, input bit r);
        exp_t e;
        bit   exp_rdy;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.clear    = c;
        resetn       = r;
        exp_rdy = r && !c && (!m_scan || OVW);
        #1;
        check("in_ready", bus.in_ready, exp_rdy);
        model_edge(v && exp_rdy, d, !r || c);
        @(posedge clk);
        #1;
        check("fill_count", bus.fill_count, m_fill);
        check("table_full", bus.table_full, m_scan);
        check("sel_valid", bus.sel_valid, m_selv);
        check("sel", bus.sel, m_sel);
        while (wr_q.size() > 0) begin
            e = wr_q.pop_front();
            check("din_slot_write", bus.din[e.idx*SLOT_W +: SLOT_W], e.val);
        end
        while (sw_q.size() > 0) begin
            e = sw_q.pop_front();
            check("sweep_sel", bus.sel, e.idx);
            check("sweep_dout", dout, e.val);
        end
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, limit 1000000 ns");
        $fatal(1);
    end

    initial begin
        vec_t vt [8];
        int   bad;
        int   prev_sel;
        bit   found;

        vt[0] = '{1'b1, 4'h3, 1'b0, 1'b1, 1, 1'b0};
        vt[1] = '{1'b0, 4'h7, 1'b0, 1'b1, 1, 1'b0};
        vt[2] = '{1'b1, 4'h5, 1'b0, 1'b1, 2, 1'b0};
        vt[3] = '{1'b1, 4'hA, 1'b1, 1'b1, 0, 1'b0};
        vt[4] = '{1'b1, 4'h9, 1'b0, 1'b1, 1, 1'b0};
        vt[5] = '{1'b1, 4'h2, 1'b0, 1'b0, 0, 1'b0};
        vt[6] = '{1'b1, 4'h4, 1'b0, 1'b1, 1, 1'b0};
        vt[7] = '{1'b1, 4'h6, 1'b0, 1'b1, 2, 1'b0};

        model_reset();

        // reset state
        do_reset();
        check("reset_din_zero", bus.din == '0, 1);
        check("reset_fill", bus.fill_count, 0);
        check("reset_sel", bus.sel, 0);
        check("reset_sel_valid", bus.sel_valid, 0);
        check("reset_full", bus.table_full, 0);
        resetn = 1'b1;
        #1;
        check("reset_release_ready", bus.in_ready, 1);

        // handshake vectors: accepts, stall, clear overriding an accept, reset
        for (int i = 0; i < 8; i++) begin
            cycle(vt[i].v, vt[i].d, vt[i].c, vt[i].r);
            check("vec_fill", bus.fill_count, vt[i].exp_fill);
            check("vec_full", bus.table_full, vt[i].exp_full);
            check_din("vec_din");
        end
        check("vec_slot1", bus.din[1*SLOT_W +: SLOT_W], 4'h6);

        // valid toggling every cycle: half the cycles accept
        do_reset();
        for (int i = 0; i < 256; i++) cycle(i % 2 == 0, SLOT_W'(i), 1'b0, 1'b1);
        check("toggle_fill_128", bus.fill_count, 128);
        check("toggle_no_scan", bus.sel_valid, 0);
        check("toggle_not_full", bus.table_full, 0);
        check_din("toggle_din");

        // clear with a same-cycle accept at fill_count 100
        do_reset();
        for (int i = 0; i < 100; i++) cycle(1'b1, SLOT_W'(i + 5), 1'b0, 1'b1);
        check("pre_clear_fill_100", bus.fill_count, 100);
        cycle(1'b1, 4'hA, 1'b1, 1'b1);
        check("clear_fill_zero", bus.fill_count, 0);
        check("clear_din_zero", bus.din == '0, 1);
        cycle(1'b1, 4'h3, 1'b0, 1'b1);
        check("post_clear_fill", bus.fill_count, 1);
        check("post_clear_slot0", bus.din[0 +: SLOT_W], 4'h3);

        // back-to-back fill of all slots, then the sweep
        do_reset();
        for (int k = 0; k < NUM_SLOTS; k++) cycle(1'b1, SLOT_W'(k % 16), 1'b0, 1'b1);
        check("full_after_256", bus.table_full, 1);
        check("first_scan_sel", bus.sel, 0);
        check("first_scan_sel_valid", bus.sel_valid, 1);
        check("full_fill_256", bus.fill_count, 256);
        bad = 0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (bus.din[k*SLOT_W +: SLOT_W] !== SLOT_W'(k % 16)) bad++;
        end
        check("fill_pattern_bad_slots", bad, 0);
        for (int i = 0; i < 255; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        check("sweep_sel_255", bus.sel, 255);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("sweep_wrap_0", bus.sel, 0);
        for (int i = 0; i < 256; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        check("sweep_still_full", bus.table_full, 1);

        // write attempt while sweeping
        prev_sel = int'(bus.sel);
        cycle(1'b1, 4'hF, 1'b0, 1'b1);
`ifdef MUX_TABLE_LOADER_OVERWRITE_EN
        check("scan_write_slot0", bus.din[0 +: SLOT_W], 4'hF);
`else
        check("scan_frozen_slot0", bus.din[0 +: SLOT_W], 4'h0);
`endif
        check("scan_write_fill_sat", bus.fill_count, 256);
        check("scan_write_sel_step", bus.sel, (prev_sel + 1) % NUM_SLOTS);
        #1;
        check("scan_in_ready", bus.in_ready, OVW);
        check_din("scan_write_din");
        for (int i = 0; i < 20; i++) cycle(1'b1, SLOT_W'(15 - i), 1'b0, 1'b1);
        check_din("scan_stream_din");

        // reset pulse mid-sweep at sel 37
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (bus.sel == 37 && bus.sel_valid) found = 1;
            else cycle(1'b0, '0, 1'b0, 1'b1);
        end
        check("reach_sel_37", found, 1);
        cycle(1'b1, 4'hF, 1'b0, 1'b0);
        check("midscan_reset_din", bus.din == '0, 1);
        check("midscan_reset_sel", bus.sel, 0);
        check("midscan_reset_sel_valid", bus.sel_valid, 0);
        check("midscan_reset_full", bus.table_full, 0);
        check("midscan_reset_fill", bus.fill_count, 0);
        resetn = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("midscan_reset_ready", bus.in_ready, 1);
        cycle(1'b1, 4'h8, 1'b0, 1'b1);
        check("after_reset_slot0", bus.din[0 +: SLOT_W], 4'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
